uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Transmit scheduler that shares the single `uarttx` serializer between several word-producing requesters (coordinate echo, status reporter, debug dump). It replaces fixed cycle-count byte spacing with a real handshake on the serializer's busy flag. It grants one requester at a time (round-robin), sends its 32-bit word MSB byte first, and acknowledges completion. It sits between the producers and `uarttx`, in the divided-clock domain.

## Interface
- `NREQ`, 3: number of requesters (2..8).
- `WORD_BYTES`, 4: bytes per word; word width is 8*WORD_BYTES.
- `START_TO`, 16: cycles to wait for `tx_busy` to rise after a `wrsig` pulse before declaring a timeout.

- `clk` in 1: divided UART-domain clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clr` in 1: synchronous abort/clear.
- `req` in NREQ: per-requester level request, held until `ack`.
- `word` in NREQ*8*WORD_BYTES: packed words; requester i at bits [32i+31:32i].
- `grant` out NREQ: one-hot, high for the whole transfer of the granted word.
- `ack` out NREQ: one-cycle pulse when the granted word's last byte has finished.
- `datain` out 8: byte to `uarttx`, stable from `wrsig` until the next `wrsig`.
- `wrsig` out 1: one-cycle send strobe to `uarttx`.
- `tx_busy` in 1: high while `uarttx` shifts a frame.
- `timeout_err` out 1: sticky; set on any start timeout.

## Operation
- States: IDLE, WAIT_START, WAIT_DONE.
- **IDLE.** If any eligible `req` is set, pick the winner round-robin: search from `last+1` upward, wrapping. Then in the same edge:
  - latch the winner's word into the shift register;
  - set `grant[i]`, set `last` to i;
  - set `datain` to the word's MSB byte and `wrsig` to 1;
  - set `byte_idx` to 0 and go to WAIT_START.
- **WAIT_START.** `wrsig` is forced to 0. If `tx_busy` = 1, go to WAIT_DONE. Otherwise count. When the count reaches START_TO-1, set `timeout_err` and take the byte-complete path.
- **WAIT_DONE.** On `tx_busy` = 0, the byte is complete:
  - If `byte_idx` = WORD_BYTES-1: pulse `ack[i]`, clear `grant`, go to IDLE.
  - Otherwise: increment `byte_idx`, set `datain` to the next byte and `wrsig` to 1, go to WAIT_START.
- Word is latched at grant. Changes to `word` or `req` during a transfer do not affect it; a dropped `req` still completes and is still acked.
- In the cycle `ack[i]` is high, `req[i]` is ineligible (masked). This prevents a stale re-grant.
- Requesters with no `req` are skipped. No starvation: worst-case wait is NREQ-1 words.
- **`clr`.** Priority below reset, above everything else. It forces the reset values and no `ack` is issued. A frame already inside `uarttx` is not recalled.
- **Reset values.** State IDLE, `grant` 0, `ack` 0, `datain` 0, `wrsig` 0, `timeout_err` 0, `byte_idx` 0, `last` = NREQ-1 (requester 0 wins the first arbitration).

## Timing
- All outputs are registered.
- `req` sampled high at edge k (state IDLE) → `grant` and `wrsig` high after edge k.
- `wrsig` is exactly one cycle wide; never two strobes without an intervening `tx_busy` fall or a timeout.
- The next byte's `wrsig` is asserted on the edge after the WAIT_DONE cycle that sees `tx_busy` = 0.
- `ack` and the `grant` drop occur on the same edge. At least one IDLE cycle separates consecutive words.
- Per-byte overhead beyond the frame time is 2 cycles.
- `last` wraps NREQ-1 → 0.

## Structure
- Package `uart_pkg`:
  - state enum;
  - `WORD_BYTES` default;
  - `BYTE_IDX_W` = clog2(WORD_BYTES);
  - timer width = clog2(START_TO).
- One sub-module, `rr_arbiter` (combinational):
  - inputs: `req & ~mask`, `last`;
  - outputs: one-hot winner, winner index, any-valid.
- The FSM, shift register and timer live in `uart_tx_sched`.

## Test plan
- **Single request.** `req` = 001, `word0` = 0x12345678, model busy for 10 cycles per byte → `datain` sequence 12, 34, 56, 78. Each is a one-cycle `wrsig`. `ack[0]` pulses once, after the 4th busy fall.
- **Round-robin.** `req` = 111 held continuously → grant order 0, 1, 2, 0. Each is acked after 4 bytes. No re-grant in the ack cycle.
- **Word stability.** Change `word1` and drop `req1` mid-transfer → the originally latched bytes are sent and `ack[1]` still pulses.
- **Start timeout.** `tx_busy` stuck at 0 → after START_TO cycles `timeout_err` = 1 and the next byte strobes. The word completes and is acked after 4 timeouts.
- **Mid-transfer abort.** `clr` after byte 2, and separately `rst_n` low after byte 1 → `grant`, `wrsig` and `ack` are 0 next cycle and state is IDLE. A new `req2` is served first by requester order from `last` = NREQ-1.
- **Busy at request.** `tx_busy` already high when `req` arrives → `wrsig` is issued. WAIT_START sees busy, WAIT_DONE waits for the fall, and only one byte is counted.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg -- state encoding and sizing helpers shared by the UART transmit scheduler.
// Revision: 1.0
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } tx_state_e;

  localparam int unsigned DEFAULT_WORD_BYTES = 4;
  localparam int unsigned DEFAULT_START_TO   = 16;

  // Width needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned BYTE_IDX_W = idx_width(DEFAULT_WORD_BYTES);
  localparam int unsigned TIMER_W    = idx_width(DEFAULT_START_TO);

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter -- combinational round-robin pick, searching upward from last+1 with wrap.
// Revision: 1.0
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic             found_hi;
  logic             found_lo;
  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;

  // Lowest requester above last wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (req_i[i]) begin
        if (i > int'(last_i)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            idx_hi   = IDX_W'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          idx_lo   = IDX_W'(i);
        end
      end
    end
    valid_o = found_hi | found_lo;
    idx_o   = found_hi ? idx_hi : idx_lo;
    gnt_o   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (valid_o && (idx_o == IDX_W'(i))) gnt_o[i] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// uart_tx_sched -- shares one uarttx serializer among NREQ word producers, MSB byte first.
// Revision: 1.0
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned WORD_BYTES = DEFAULT_WORD_BYTES,
  parameter int unsigned START_TO   = DEFAULT_START_TO
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*8*WORD_BYTES-1:0] word,
  output logic [NREQ-1:0]             grant,
  output logic [NREQ-1:0]             ack,
  output logic [7:0]                  datain,
  output logic                        wrsig,
  input  logic                        tx_busy,
  output logic                        timeout_err
);

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned REQ_W  = idx_width(NREQ);
  localparam int unsigned BIW    = (WORD_BYTES == DEFAULT_WORD_BYTES) ? BYTE_IDX_W
                                                                      : idx_width(WORD_BYTES);
  localparam int unsigned TW     = (START_TO == DEFAULT_START_TO) ? TIMER_W
                                                                  : idx_width(START_TO);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(START_TO - 1);
  localparam logic [BIW-1:0]   BYTE_LAST  = BIW'(WORD_BYTES - 1);
  localparam logic [REQ_W-1:0] LAST_RST   = REQ_W'(NREQ - 1);

  tx_state_e          state_q;
  logic [NREQ-1:0]    grant_q;
  logic [NREQ-1:0]    ack_q;
  logic [7:0]         datain_q;
  logic               wrsig_q;
  logic               terr_q;
  logic [BIW-1:0]     byte_idx_q;
  logic [REQ_W-1:0]   last_q;
  logic [WORD_W-1:0]  shreg_q;
  logic [TW-1:0]      timer_q;

  logic [NREQ-1:0]    arb_gnt;
  logic [REQ_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [WORD_W-1:0]  word_sel;
  logic [WORD_W-1:0]  shreg_d;
  logic               byte_done;

  // A requester being acked this cycle is masked so its still-high req is not re-granted.
  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (REQ_W)
  ) u_arb (
    .req_i   (req & ~ack_q),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (arb_gnt[i]) word_sel = word[i*WORD_W +: WORD_W];
    end
  end

  assign shreg_d   = shreg_q << 8;
  assign byte_done = !tx_busy &&
                     ((state_q == ST_WAIT_DONE) ||
                      ((state_q == ST_WAIT_START) && (timer_q == TIMER_LAST)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      datain_q   <= '0;
      wrsig_q    <= 1'b0;
      terr_q     <= 1'b0;
      byte_idx_q <= '0;
      last_q     <= LAST_RST;
      shreg_q    <= '0;
      timer_q    <= '0;
    end else if (clr) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      datain_q   <= '0;
      wrsig_q    <= 1'b0;
      terr_q     <= 1'b0;
      byte_idx_q <= '0;
      last_q     <= LAST_RST;
      shreg_q    <= '0;
      timer_q    <= '0;
    end else begin
      ack_q   <= '0;
      wrsig_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q    <= arb_gnt;
            last_q     <= arb_idx;
            shreg_q    <= word_sel;
            datain_q   <= word_sel[WORD_W-1 -: 8];
            wrsig_q    <= 1'b1;
            byte_idx_q <= '0;
            timer_q    <= '0;
            state_q    <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (tx_busy)                     state_q <= ST_WAIT_DONE;
          else if (timer_q == TIMER_LAST)  terr_q  <= 1'b1;
          else                             timer_q <= timer_q + 1'b1;
        end
        ST_WAIT_DONE: ;
        default: state_q <= ST_IDLE;
      endcase

      // Busy fall or start timeout: finish the word or strobe the next byte.
      if (byte_done) begin
        if (byte_idx_q == BYTE_LAST) begin
          ack_q   <= grant_q;
          grant_q <= '0;
          state_q <= ST_IDLE;
        end else begin
          byte_idx_q <= byte_idx_q + 1'b1;
          shreg_q    <= shreg_d;
          datain_q   <= shreg_d[WORD_W-1 -: 8];
          wrsig_q    <= 1'b1;
          timer_q    <= '0;
          state_q    <= ST_WAIT_START;
        end
      end
    end
  end

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign datain      = datain_q;
  assign wrsig       = wrsig_q;
  assign timeout_err = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// tb_uart_tx_sched -- randomized bench for uart_tx_sched against a word-level reference model.
// Revision: 1.0
module tb_uart_tx_sched;

  localparam int NREQ     = 3;
  localparam int WB       = 4;
  localparam int START_TO = 16;
  localparam int WW       = 8 * WB;

  logic                 clk     = 1'b0;
  logic                 rst_n   = 1'b0;
  logic                 clr     = 1'b0;
  logic                 tx_busy = 1'b0;
  logic [NREQ-1:0]      req     = '0;
  logic [NREQ*WW-1:0]   word    = '0;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      ack;
  logic [7:0]           datain;
  logic                 wrsig;
  logic                 timeout_err;

  uart_tx_sched #(
    .NREQ       (NREQ),
    .WORD_BYTES (WB),
    .START_TO   (START_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .req         (req),
    .word        (word),
    .grant       (grant),
    .ack         (ack),
    .datain      (datain),
    .wrsig       (wrsig),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs as the DUT saw them at the most recent rising edge.
  logic               s_rst_n = 1'b0;
  logic               s_clr   = 1'b0;
  logic               s_busy  = 1'b0;
  logic [NREQ-1:0]    s_req   = '0;
  logic [NREQ*WW-1:0] s_word  = '0;

  initial forever begin
    @(posedge clk);
    s_rst_n = rst_n;
    s_clr   = clr;
    s_busy  = tx_busy;
    s_req   = req;
    s_word  = word;
  end

  // Reference model: one word in flight, a queue of its remaining bytes.
  bit              m_active = 1'b0;
  int              m_phase  = 0;
  int              m_n      = 0;
  int              m_last   = NREQ - 1;
  logic [7:0]      m_q[$];
  logic [NREQ-1:0] e_grant  = '0;
  logic [NREQ-1:0] e_ack    = '0;
  logic [7:0]      e_dat    = '0;
  logic            e_wr     = 1'b0;
  logic            e_terr   = 1'b0;

  function automatic int rr_pick(input logic [NREQ-1:0] elig, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [NREQ-1:0] mask;
    bit done;
    int w;
    mask  = e_ack;
    e_ack = '0;
    e_wr  = 1'b0;
    if (!s_rst_n || s_clr) begin
      m_active = 1'b0;
      e_grant  = '0;
      e_dat    = '0;
      e_terr   = 1'b0;
      m_last   = NREQ - 1;
      m_q.delete();
    end else if (!m_active) begin
      w = rr_pick(s_req & ~mask, m_last);
      if (w >= 0) begin
        m_active = 1'b1;
        m_last   = w;
        e_grant  = '0;
        e_grant[w] = 1'b1;
        for (int b = WB - 1; b >= 0; b--) m_q.push_back(s_word[w*WW + b*8 +: 8]);
        e_dat   = m_q.pop_front();
        e_wr    = 1'b1;
        m_phase = 0;
        m_n     = 0;
      end
    end else begin
      done = 1'b0;
      if (m_phase == 0) begin
        m_n++;
        if (s_busy) m_phase = 1;
        else if (m_n == START_TO) begin
          e_terr = 1'b1;
          done   = 1'b1;
        end
      end else if (!s_busy) begin
        done = 1'b1;
      end
      if (done) begin
        if (m_q.size() == 0) begin
          e_ack    = e_grant;
          e_grant  = '0;
          m_active = 1'b0;
        end else begin
          e_dat   = m_q.pop_front();
          e_wr    = 1'b1;
          m_phase = 0;
          m_n     = 0;
        end
      end
    end
  endtask

  // uarttx stand-in: 0 = frames after each strobe, 1 = busy stuck low, 2 = busy stuck high.
  int u_mode      = 0;
  int u_pend      = 0;
  int u_frame     = 0;
  int fixed_frame = 0;

  logic [7:0]      seen[$];
  int              glog[$];
  int              wr_cnt  = 0;
  int              ack_cnt = 0;
  int              ack_per[NREQ];
  logic [NREQ-1:0] prev_grant = '0;

  initial begin
    for (int i = 0; i < NREQ; i++) ack_per[i] = 0;
    forever begin
      @(negedge clk);
      model_step();
      chk("grant", {61'd0, grant}, {61'd0, e_grant});
      chk("ack", {61'd0, ack}, {61'd0, e_ack});
      chk("wrsig", {63'd0, wrsig}, {63'd0, e_wr});
      chk("datain", {56'd0, datain}, {56'd0, e_dat});
      chk("timeout_err", {63'd0, timeout_err}, {63'd0, e_terr});
      if (wrsig) begin
        seen.push_back(datain);
        wr_cnt++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          ack_cnt++;
          ack_per[i]++;
        end
        if (grant[i] && prev_grant == '0) glog.push_back(i);
      end
      prev_grant = grant;
      if (wrsig) begin
        u_pend  = (fixed_frame != 0) ? 0 : int'($urandom_range(0, 2));
        u_frame = (fixed_frame != 0) ? fixed_frame : int'($urandom_range(2, 12));
      end
      case (u_mode)
        1: tx_busy = 1'b0;
        2: tx_busy = 1'b1;
        default: begin
          if (u_pend > 0) begin
            u_pend--;
            tx_busy = 1'b0;
          end else if (u_frame > 0) begin
            u_frame--;
            tx_busy = 1'b1;
          end else begin
            tx_busy = 1'b0;
          end
        end
      endcase
    end
  end

  bit agent_on = 1'b0;

  task automatic tick();
    @(negedge clk);
    #1;
    if (agent_on) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          req[i] = 1'b0;
          word[i*WW +: WW] = $urandom();
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int target;
    int k;
    target = ack_cnt + n;
    k = 0;
    while (ack_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(ack_cnt), 64'(target));
  endtask

  task automatic wait_wr(input int n, input int budget, input string tag);
    int target;
    int k;
    target = wr_cnt + n;
    k = 0;
    while (wr_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(wr_cnt), 64'(target));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  logic [7:0] exp_single[4];
  int         exp_rr[4];
  logic [31:0] wv;
  int a0;
  int w0;

  initial begin
    exp_single = '{8'h12, 8'h34, 8'h56, 8'h78};
    exp_rr     = '{0, 1, 2, 0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_grant", {61'd0, grant}, 64'd0);
    chk("rst_wrsig", {63'd0, wrsig}, 64'd0);
    chk("rst_datain", {56'd0, datain}, 64'd0);
    chk("rst_terr", {63'd0, timeout_err}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request, fixed 10-cycle frames
    fixed_frame = 10;
    word[0 +: WW] = 32'h12345678;
    seen.delete();
    a0  = ack_per[0];
    req = 3'b001;
    wait_acks(1, 400, "single_done");
    req = '0;
    repeat (3) tick();
    chk("single_nbytes", 64'(seen.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (seen.size() > k) chk("single_byte", {56'd0, seen[k]}, {56'd0, exp_single[k]});
    chk("single_ack0", 64'(ack_per[0] - a0), 64'd1);
    chk("single_idle_grant", {61'd0, grant}, 64'd0);

    // Round-robin with all requests held
    fixed_frame = 0;
    pulse_clr();
    glog.delete();
    w0  = wr_cnt;
    req = 3'b111;
    wait_acks(4, 2000, "rr_done");
    req = '0;
    chk("rr_ngrants", 64'(glog.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (glog.size() > k) chk("rr_order", 64'(glog[k]), 64'(exp_rr[k]));
    chk("rr_nbytes", 64'(wr_cnt - w0), 64'd16);

    // Word and req changes mid-transfer do not disturb the latched word
    pulse_clr();
    seen.delete();
    word[WW +: WW] = 32'hA1B2C3D4;
    a0  = ack_per[1];
    req = 3'b010;
    wait_wr(2, 200, "stab_wr2");
    word[WW +: WW] = 32'h5A5A5A5A;
    req = '0;
    wait_acks(1, 400, "stab_done");
    wv = 32'hA1B2C3D4;
    chk("stab_nbytes", 64'(seen.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (seen.size() > k) chk("stab_byte", {56'd0, seen[k]}, {56'd0, wv[31-8*k -: 8]});
    chk("stab_ack1", 64'(ack_per[1] - a0), 64'd1);

    // Start timeout: busy never rises
    pulse_clr();
    u_mode = 1;
    seen.delete();
    wv = $urandom();
    word[0 +: WW] = wv;
    req = 3'b001;
    wait_acks(1, 4 * START_TO + 40, "to_done");
    req = '0;
    tick();
    chk("to_flag", {63'd0, timeout_err}, 64'd1);
    chk("to_nbytes", 64'(seen.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      if (seen.size() > k) chk("to_byte", {56'd0, seen[k]}, {56'd0, wv[31-8*k -: 8]});
    u_mode = 0;

    // clr after byte 2 completes, then req2 alone
    pulse_clr();
    req = 3'b001;
    wait_wr(3, 300, "clr_wr3");
    clr = 1'b1;
    req = '0;
    tick();
    clr = 1'b0;
    chk("clr_grant", {61'd0, grant}, 64'd0);
    chk("clr_wrsig", {63'd0, wrsig}, 64'd0);
    chk("clr_ack", {61'd0, ack}, 64'd0);
    glog.delete();
    req = 3'b100;
    wait_acks(1, 400, "clr_req2_done");
    req = '0;
    chk("clr_req2_first", (glog.size() > 0) ? 64'(glog[0]) : 64'hFF, 64'd2);

    // Asynchronous reset after byte 1, then req2 alone
    req = 3'b001;
    wait_wr(2, 300, "rst_wr2");
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("arst_grant", {61'd0, grant}, 64'd0);
    chk("arst_wrsig", {63'd0, wrsig}, 64'd0);
    chk("arst_ack", {61'd0, ack}, 64'd0);
    tick();
    rst_n = 1'b1;
    glog.delete();
    req = 3'b100;
    wait_acks(1, 400, "arst_req2_done");
    req = '0;
    chk("arst_req2_first", (glog.size() > 0) ? 64'(glog[0]) : 64'hFF, 64'd2);

    // Busy already high when the request arrives
    u_mode = 2;
    tick();
    tick();
    w0  = wr_cnt;
    req = 3'b010;
    repeat (30) tick();
    chk("busyreq_wr", 64'(wr_cnt - w0), 64'd1);
    chk("busyreq_grant", {61'd0, grant}, 64'b010);
    u_mode = 0;
    wait_acks(1, 400, "busyreq_done");
    req = '0;
    chk("busyreq_nbytes", 64'(wr_cnt - w0), 64'd4);

    // Randomized traffic with occasional clr and stuck-busy stretches
    pulse_clr();
    a0 = ack_cnt;
    agent_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) pulse_clr();
      if (c % 250 == 0) u_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
    end
    agent_on = 1'b0;
    req    = '0;
    u_mode = 0;
    repeat (200) tick();
    chk("rand_progress", 64'(ack_cnt - a0 > 20), 64'd1);
    chk("rand_idle_grant", {61'd0, grant}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
